pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the decode->AGEX boundary of the 5-stage RV64 core.
//  - Generates the latch enables and the injected valid bit for the decode stage.
//  - Detects load-use hazards with a per-register in-flight-load scoreboard.
//  - Holds fetch while a branch, jump or ECALL resolves.
//  - Drains the pipe around ECALL.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/load_scoreboard.sv | 61 ++++++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the decode->AGEX hazard controller: FSM states,
// RV64 opcode constants and small opcode-class helpers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        EC_DRAIN = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP_OP || op == OP_OP32 || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return op == OP_BRANCH || op == OP_JALR || op == OP_JAL;
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// Per-register in-flight-load counters with two source busy lookups and a
// destination saturation lookup. x0 is never tracked.
module load_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int RID_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [RID_W-1:0] inc_id,
    input  logic             dec_en,
    input  logic [RID_W-1:0] dec_id,
    input  logic [RID_W-1:0] rs1_id,
    input  logic [RID_W-1:0] rs2_id,
    input  logic [RID_W-1:0] rd_id,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc_hit, dec_hit;

    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_hit[r] = inc_en && (inc_id == RID_W'(r));
            dec_hit[r] = dec_en && (dec_id == RID_W'(r));
        end
    end

    // Same-cycle inc and dec cancel; inc stops at saturation, dec at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (clr || r == 0)
                    cnt[r] <= '0;
                else if (inc_hit[r] && !dec_hit[r] && cnt[r] != CNT_MAX)
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_hit[r] && !inc_hit[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

    // A last outstanding load sitting in WB is forwarded, so it is not busy.
    assign rs1_busy = (rs1_id != '0) && (cnt[rs1_id] != '0)
                      && !((cnt[rs1_id] == CNT_ONE) && dec_hit[rs1_id]);
    assign rs2_busy = (rs2_id != '0) && (cnt[rs2_id] != '0)
                      && !((cnt[rs2_id] == CNT_ONE) && dec_hit[rs2_id]);
    assign rd_sat   = (rd_id != '0) && (cnt[rd_id] == CNT_MAX);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode->AGEX sequencer: load-use stalls, branch/ECALL holds and latch enables.
// Optional stall counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_v,
    input  logic [31:0]       de_ir,
    input  logic              mem_stall,
    input  logic              wb_v,
    input  logic              wb_is_load,
    input  logic [4:0]        wb_drid,
    input  logic              br_resolved,
    input  logic              ecall_done,
    output logic              ld_de,
    output logic              ld_agex,
    output logic              exe_v_in,
    output logic              de_br_stall,
    output logic              flush_de,
    output logic              ecall_busy,
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_br,
    output logic [PERF_W-1:0] perf_ms
);

    state_t      state, state_nxt;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_busy, rs2_busy, rd_sat;
    logic        is_load, hazard;
    logic        ld_de_c, ld_agex_c, exe_v_c, br_stall_c, flush_c, ec_busy_c;
    logic        sb_clr, lu_stall;

    assign opcode  = de_ir[6:0];
    assign rd      = de_ir[11:7];
    assign rs1     = de_ir[19:15];
    assign rs2     = de_ir[24:20];
    assign is_load = opcode == OP_LOAD;
    assign hazard  = de_v && ((uses_rs1(opcode) && rs1_busy) ||
                              (uses_rs2(opcode) && rs2_busy) ||
                              (is_load && rd_sat));

    load_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .RID_W(5)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .clr      (sb_clr),
        .inc_en   (ld_agex_c && exe_v_c && is_load && rd != 5'd0),
        .inc_id   (rd),
        .dec_en   (wb_v && wb_is_load),
        .dec_id   (wb_drid),
        .rs1_id   (rs1),
        .rs2_id   (rs2),
        .rd_id    (rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_sat   (rd_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ld_de_c    = 1'b0;
        ld_agex_c  = 1'b0;
        exe_v_c    = 1'b0;
        br_stall_c = 1'b0;
        flush_c    = 1'b0;
        ec_busy_c  = 1'b0;
        sb_clr     = 1'b0;
        lu_stall   = 1'b0;
        if (mem_stall) begin
            // Everything freezes; only the status of the held state stays visible.
            br_stall_c = state == BR_WAIT;
            ec_busy_c  = state == EC_DRAIN;
        end else begin
            case (state)
                RUN: begin
                    ld_agex_c = 1'b1;
                    if (!de_v) begin
                        ld_de_c = 1'b1;
                    end else if (hazard) begin
                        lu_stall = 1'b1;
                    end else if (is_ctrl(opcode)) begin
                        ld_de_c    = 1'b1;
                        exe_v_c    = 1'b1;
                        br_stall_c = 1'b1;
                        state_nxt  = BR_WAIT;
                    end else if (de_ir == ECALL_WORD) begin
                        exe_v_c   = 1'b1;
                        state_nxt = EC_DRAIN;
                    end else begin
                        ld_de_c = 1'b1;
                        exe_v_c = 1'b1;
                    end
                end
                BR_WAIT: begin
                    ld_de_c    = 1'b1;
                    ld_agex_c  = 1'b1;
                    br_stall_c = !br_resolved;
                    if (br_resolved) state_nxt = RUN;
                end
                EC_DRAIN: begin
                    ld_agex_c = 1'b1;
                    ec_busy_c = 1'b1;
                    if (ecall_done) state_nxt = FLUSH;
                end
                default: begin
                    ld_de_c   = 1'b1;
                    ld_agex_c = 1'b1;
                    flush_c   = 1'b1;
                    sb_clr    = 1'b1;
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign ld_de       = ld_de_c    && !rst;
    assign ld_agex     = ld_agex_c  && !rst;
    assign exe_v_in    = exe_v_c    && !rst;
    assign de_br_stall = br_stall_c && !rst;
    assign flush_de    = flush_c    && !rst;
    assign ecall_busy  = ec_busy_c  && !rst;

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu <= '0;
            perf_br <= '0;
            perf_ms <= '0;
        end else begin
            if (lu_stall)         perf_lu <= perf_lu + 1'b1;
            if (state == BR_WAIT) perf_br <= perf_br + 1'b1;
            if (mem_stall)        perf_ms <= perf_ms + 1'b1;
        end
    end
`else
    logic unused_lu_stall;
    assign unused_lu_stall = lu_stall;
    assign perf_lu = '0;
    assign perf_br = '0;
    assign perf_ms = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; output bundle is
// {ld_de, ld_agex, exe_v_in, de_br_stall, flush_de, ecall_busy}.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        de_v, mem_stall, wb_v, wb_is_load, br_resolved, ecall_done;
    logic [31:0] de_ir;
    logic [4:0]  wb_drid;
    logic        ld_de, ld_agex, exe_v_in, de_br_stall, flush_de, ecall_busy;
    logic [31:0] perf_lu, perf_br, perf_ms;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NREG(32), .CNT_W(2), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .de_v(de_v), .de_ir(de_ir), .mem_stall(mem_stall),
        .wb_v(wb_v), .wb_is_load(wb_is_load), .wb_drid(wb_drid),
        .br_resolved(br_resolved), .ecall_done(ecall_done),
        .ld_de(ld_de), .ld_agex(ld_agex), .exe_v_in(exe_v_in),
        .de_br_stall(de_br_stall), .flush_de(flush_de), .ecall_busy(ecall_busy),
        .perf_lu(perf_lu), .perf_br(perf_br), .perf_ms(perf_ms)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_ld(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b011, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
    endfunction

    task automatic put(input logic v, input logic [31:0] ir);
        de_v = v; de_ir = ir;
        mem_stall = 0; wb_v = 0; wb_is_load = 0; wb_drid = 0;
        br_resolved = 0; ecall_done = 0;
    endtask

    task automatic wb_load(input logic [4:0] id);
        wb_v = 1; wb_is_load = 1; wb_drid = id;
    endtask

    // Check the combinational bundle mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [5:0] exp);
        #1;
        chk(tag, {26'd0, ld_de, ld_agex, exe_v_in, de_br_stall, flush_de, ecall_busy},
            {26'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic chk_perf(input string tag, input int lu, input int br, input int ms);
`ifdef PIPE_PERF_CNT_EN
        chk({tag, "_lu"}, perf_lu, lu);
        chk({tag, "_br"}, perf_br, br);
        chk({tag, "_ms"}, perf_ms, ms);
`else
        chk({tag, "_lu"}, perf_lu, 0);
        chk({tag, "_br"}, perf_br, 0);
        chk({tag, "_ms"}, perf_ms, 0 * (lu + br + ms));
`endif
    endtask

    initial begin
        rst = 1;
        put(1, i_add(6, 5, 1));
        step("reset_outs", 6'b000000);
        chk_perf("reset_perf", 0, 0, 0);
        rst = 0;

        // load-use on x5, then forwarded once the load is in WB
        put(1, i_ld(5, 1));            step("ld_x5_issue",   6'b111000);
        put(1, i_add(6, 5, 1));        step("lu_bubble",     6'b010000);
        put(1, i_add(6, 5, 1));        wb_load(5); step("lu_fwd_wb", 6'b111000);
        put(1, i_add(6, 5, 1));        step("lu_cleared",    6'b111000);

        // x0 destination is never tracked
        put(1, i_ld(0, 1));            step("ld_x0_issue",   6'b111000);
        put(1, i_add(1, 0, 0));        step("x0_no_stall",   6'b111000);

        // saturate cnt[7] at 3
        put(1, i_ld(7, 1));            step("ld_x7_a",       6'b111000);
        put(1, i_ld(7, 1));            step("ld_x7_b",       6'b111000);
        put(1, i_ld(7, 1));            step("ld_x7_c",       6'b111000);
        put(1, i_ld(7, 1));            step("ld_x7_sat",     6'b010000);
        put(1, i_add(8, 7, 0));        wb_load(7); step("cnt3_dec_busy", 6'b010000);

        // branch: 3 BR_WAIT cycles of bubbles
        put(1, i_beq(1, 2));           step("beq_issue",     6'b111100);
        put(1, i_add(9, 1, 2));        step("br_wait_1",     6'b110100);
        put(1, i_add(9, 1, 2));        step("br_wait_2",     6'b110100);
        put(1, i_add(9, 1, 2));        br_resolved = 1; step("br_resolve", 6'b110000);
        put(0, 32'd0);                 #1; chk_perf("perf_mid", 3, 3, 0);
        br_resolved = 1; ecall_done = 1; step("stray_pulses", 6'b110000);
        put(0, 32'd0);                 step("still_run",     6'b110000);

        // reset in BR_WAIT with cnt[7] = 2
        put(1, i_beq(1, 2));           step("beq2_issue",    6'b111100);
        put(1, i_add(9, 1, 2));        rst = 1; step("rst_mid", 6'b000000);
        rst = 0;
        put(1, i_add(8, 7, 0));        step("post_rst_cnt0", 6'b111000);

        // ECALL drain and flush clears the scoreboard
        put(1, i_ld(10, 1));           step("ld_x10_issue",  6'b111000);
        put(1, 32'h0000_0073);         step("ecall_issue",   6'b011000);
        put(1, i_add(11, 10, 0));      step("ec_drain_1",    6'b010001);
        put(1, i_add(11, 10, 0));      br_resolved = 1; step("ec_drain_2", 6'b010001);
        put(1, i_add(11, 10, 0));      ecall_done = 1; step("ec_done", 6'b010001);
        put(1, i_add(11, 10, 0));      step("flush",         6'b110010);
        put(1, i_add(11, 10, 0));      step("sb_cleared",    6'b111000);

        // MEM_STALL for 3 cycles over a hazard; WB decrement lands meanwhile
        put(1, i_ld(12, 1));           step("ld_x12_issue",  6'b111000);
        put(1, i_add(13, 12, 0));      step("ms_hazard",     6'b010000);
        put(1, i_add(13, 12, 0));      mem_stall = 1; step("ms_1", 6'b000000);
        put(1, i_add(13, 12, 0));      mem_stall = 1; wb_load(12); step("ms_2", 6'b000000);
        put(1, i_add(13, 12, 0));      mem_stall = 1; step("ms_3", 6'b000000);
        put(1, i_add(13, 12, 0));      step("ms_release",    6'b111000);
        put(0, 32'd0);                 #1; chk_perf("perf_end", 1, 0, 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
